// File: rtl/alu_exec_unit_if.sv
// Request/response bundle between operand delivery and the ALU execute unit.
// The master side drives the request and out_ready. The slave side is the execute unit.
interface alu_exec_unit_if #(
   parameter int unsigned XLEN = 32
);
   logic            in_valid;
   logic            in_ready;
   logic [3:0]      alu_contrl;
   logic [XLEN-1:0] op_a;
   logic [XLEN-1:0] op_b;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] result;
   logic            zero;
   logic            illegal;
   logic            busy;

   modport master (
      output in_valid, alu_contrl, op_a, op_b, out_ready,
      input  in_ready, out_valid, result, zero, illegal, busy
   );

   modport slave (
      input  in_valid, alu_contrl, op_a, op_b, out_ready,
      output in_ready, out_valid, result, zero, illegal, busy
   );
endinterface

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle ops, iterative serial shifter, registered result
// returned over a valid/ready handshake.
module alu_exec_unit #(
   parameter int unsigned XLEN       = 32,
   parameter int unsigned SHIFT_STEP = 1
) (
   input logic            clk,
   input logic            rst,
   alu_exec_unit_if.slave bus_io
);
   typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;
   typedef enum logic [1:0] {ShSll, ShSrl, ShSra} shift_e;

   localparam logic [3:0] OpAdd  = 4'b0000;
   localparam logic [3:0] OpSub  = 4'b1000;
   localparam logic [3:0] OpSll  = 4'b0001;
   localparam logic [3:0] OpSlt  = 4'b0010;
   localparam logic [3:0] OpSltu = 4'b0011;
   localparam logic [3:0] OpXor  = 4'b0100;
   localparam logic [3:0] OpSrl  = 4'b0101;
   localparam logic [3:0] OpSra  = 4'b1101;
   localparam logic [3:0] OpOr   = 4'b0110;
   localparam logic [3:0] OpAnd  = 4'b0111;
   localparam logic [5:0] StepMax = 6'(SHIFT_STEP);

   state_e          state_q, state_d;
   shift_e          sh_type_q, sh_type_d;
   logic            sh_sign_q, sh_sign_d;
   logic [XLEN-1:0] sh_q, sh_d;
   logic [5:0]      rem_q, rem_d;
   logic [XLEN-1:0] result_q, result_d;
   logic            zero_q, zero_d;
   logic            illegal_q, illegal_d;

   logic [XLEN-1:0] op_a, op_b;
   logic [4:0]      shamt;
   logic            in_ready, accept;
   logic            is_shift;
   shift_e          in_sh_type;
   logic [XLEN-1:0] alu_res;
   logic            alu_ill;
   logic [5:0]      step;
   logic [XLEN-1:0] sh_next;

   assign op_a   = bus_io.op_a;
   assign op_b   = bus_io.op_b;
   assign shamt  = op_b[4:0];

   assign in_ready = !rst && (state_q == StIdle || (state_q == StDone && bus_io.out_ready));
   assign accept   = bus_io.in_valid && in_ready;

   // Full-width one-cycle result; also serves shifts with shamt == 0.
   always_comb begin
      alu_res    = '0;
      alu_ill    = 1'b0;
      is_shift   = 1'b0;
      in_sh_type = ShSll;
      case (bus_io.alu_contrl)
         OpAdd:  alu_res = op_a + op_b;
         OpSub:  alu_res = op_a - op_b;
         OpSll: begin
            alu_res    = op_a << shamt;
            is_shift   = 1'b1;
            in_sh_type = ShSll;
         end
         OpSlt:  alu_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
         OpSltu: alu_res = {{(XLEN-1){1'b0}}, op_a < op_b};
         OpXor:  alu_res = op_a ^ op_b;
         OpSrl: begin
            alu_res    = op_a >> shamt;
            is_shift   = 1'b1;
            in_sh_type = ShSrl;
         end
         OpSra: begin
            alu_res    = $unsigned($signed(op_a) >>> shamt);
            is_shift   = 1'b1;
            in_sh_type = ShSra;
         end
         OpOr:   alu_res = op_a | op_b;
         OpAnd:  alu_res = op_a & op_b;
         default: alu_ill = 1'b1;
      endcase
   end

   assign step = (rem_q > StepMax) ? StepMax : rem_q;

   always_comb begin
      sh_next = '0;
      if (sh_type_q == ShSll) begin
         sh_next = sh_q << step;
      end else begin
         sh_next = sh_q >> step;
         if (sh_type_q == ShSra && sh_sign_q) begin
            sh_next = sh_next | ~({XLEN{1'b1}} >> step);
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      sh_type_d = sh_type_q;
      sh_sign_d = sh_sign_q;
      sh_d      = sh_q;
      rem_d     = rem_q;
      result_d  = result_q;
      zero_d    = zero_q;
      illegal_d = illegal_q;
      unique case (state_q)
         StIdle, StDone: begin
            if (accept) begin
               if (is_shift && shamt != 5'd0) begin
                  sh_d      = op_a;
                  rem_d     = {1'b0, shamt};
                  sh_type_d = in_sh_type;
                  sh_sign_d = op_a[XLEN-1];
                  state_d   = StShift;
               end else begin
                  result_d  = alu_res;
                  zero_d    = (alu_res == '0);
                  illegal_d = alu_ill;
                  state_d   = StDone;
               end
            end else if (state_q == StDone && bus_io.out_ready) begin
               state_d = StIdle;
            end
         end
         StShift: begin
            sh_d  = sh_next;
            rem_d = rem_q - step;
            if (rem_q == step) begin
               result_d  = sh_next;
               zero_d    = (sh_next == '0);
               illegal_d = 1'b0;
               state_d   = StDone;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         sh_type_q <= ShSll;
         sh_sign_q <= 1'b0;
         sh_q      <= '0;
         rem_q     <= '0;
         result_q  <= '0;
         zero_q    <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         sh_type_q <= sh_type_d;
         sh_sign_q <= sh_sign_d;
         sh_q      <= sh_d;
         rem_q     <= rem_d;
         result_q  <= result_d;
         zero_q    <= zero_d;
         illegal_q <= illegal_d;
      end
   end

   assign bus_io.in_ready  = in_ready;
   assign bus_io.out_valid = (state_q == StDone);
   assign bus_io.busy      = (state_q == StShift);
   assign bus_io.result    = result_q;
   assign bus_io.zero      = zero_q;
   assign bus_io.illegal   = illegal_q;
endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: directed vectors, a transaction-level reference model
// checked every cycle, and literal expectations for both SHIFT_STEP = 1 and 4.
module tb_alu_exec_unit;
   localparam int STEP = 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;

   alu_exec_unit_if #(.XLEN(32)) bus ();
   alu_exec_unit_if #(.XLEN(32)) bus4 ();

   alu_exec_unit #(.XLEN(32), .SHIFT_STEP(STEP)) u_dut (
      .clk    (clk),
      .rst    (rst),
      .bus_io (bus)
   );

   alu_exec_unit #(.XLEN(32), .SHIFT_STEP(4)) u_dut4 (
      .clk    (clk),
      .rst    (rst),
      .bus_io (bus4)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   typedef struct packed {
      logic [31:0] res;
      logic        zero;
      logic        ill;
   } exp_t;

   typedef struct {
      exp_t e;
      int   acc;
      int   lat;
   } item_t;

   item_t q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic exp_t model(input logic [3:0] c, input logic [31:0] a,
                                  input logic [31:0] b);
      exp_t m;
      int   sh;
      sh    = int'(b[4:0]);
      m.ill = 1'b0;
      case (c)
         4'b0000: m.res = a + b;
         4'b1000: m.res = a - b;
         4'b0001: m.res = a << sh;
         4'b0010: m.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'b0011: m.res = (a < b) ? 32'd1 : 32'd0;
         4'b0100: m.res = a ^ b;
         4'b0101: m.res = a >> sh;
         4'b1101: m.res = $unsigned($signed(a) >>> sh);
         4'b0110: m.res = a | b;
         4'b0111: m.res = a & b;
         default: begin
            m.res = 32'd0;
            m.ill = 1'b1;
         end
      endcase
      m.zero = (m.res == 32'd0);
      return m;
   endfunction

   function automatic int lat_of(input logic [3:0] c, input logic [31:0] b);
      int sh;
      sh = int'(b[4:0]);
      if ((c == 4'b0001 || c == 4'b0101 || c == 4'b1101) && sh != 0)
         return (sh + STEP - 1) / STEP + 1;
      return 1;
   endfunction

   // Reference check, every cycle, on the main unit.
   always @(negedge clk) begin
      logic  ov_exp, busy_exp, ir_exp;
      item_t it;
      if (cyc >= 1) begin
         ov_exp   = 1'b0;
         busy_exp = 1'b0;
         if (q.size() > 0) begin
            ov_exp   = (cyc >= q[0].acc + q[0].lat - 1);
            busy_exp = !ov_exp && q[0].lat > 1;
         end
         ir_exp = !rst && !busy_exp && (!ov_exp || bus.out_ready);
         chk("out_valid", {31'd0, bus.out_valid}, {31'd0, ov_exp});
         chk("busy", {31'd0, bus.busy}, {31'd0, busy_exp});
         chk("in_ready", {31'd0, bus.in_ready}, {31'd0, ir_exp});
         if (ov_exp) begin
            chk("model result", bus.result, q[0].e.res);
            chk("model zero", {31'd0, bus.zero}, {31'd0, q[0].e.zero});
            chk("model illegal", {31'd0, bus.illegal}, {31'd0, q[0].e.ill});
         end
         if (rst) begin
            q.delete();
         end else begin
            if (ov_exp && bus.out_ready) void'(q.pop_front());
            if (bus.in_valid && ir_exp) begin
               it.e   = model(bus.alu_contrl, bus.op_a, bus.op_b);
               it.acc = cyc + 1;
               it.lat = lat_of(bus.alu_contrl, bus.op_b);
               q.push_back(it);
            end
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Returns one time unit after the accepting edge.
   task automatic send(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
      int n;
      bit got;
      n              = 0;
      got            = 1'b0;
      bus.in_valid   = 1'b1;
      bus.alu_contrl = c;
      bus.op_a       = a;
      bus.op_b       = b;
      while (!got && n < 100) begin
         @(negedge clk);
         got = bus.in_ready;
         @(posedge clk);
         #1;
         n++;
      end
      if (!got) chk("accept timeout", 32'd0, 32'd1);
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_valid(output int lat);
      int n;
      n = 0;
      while (!bus.out_valid && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      lat = n + 1;
   endtask

   typedef struct {
      logic [3:0]  c;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] r;
   } vec_t;

   vec_t vecs[9] = '{
      '{4'b0100, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFF00FF00},
      '{4'b0110, 32'h00FF0000, 32'h000000FF, 32'h00FF00FF},
      '{4'b0111, 32'hFF00FF00, 32'h0FF00FF0, 32'h0F000F00},
      '{4'b0101, 32'h12345678, 32'h00000100, 32'h12345678},
      '{4'b1101, 32'h80001234, 32'hFFFFFF08, 32'hFF800012},
      '{4'b0001, 32'h00000003, 32'h00000005, 32'h00000060},
      '{4'b0101, 32'h80000000, 32'h0000001F, 32'h00000001},
      '{4'b1000, 32'h00000000, 32'h00000001, 32'hFFFFFFFF},
      '{4'b0000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000}
   };

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin
      int lat;
      bus.in_valid    = 1'b0;
      bus.alu_contrl  = 4'd0;
      bus.op_a        = 32'd0;
      bus.op_b        = 32'd0;
      bus.out_ready   = 1'b1;
      bus4.in_valid   = 1'b0;
      bus4.alu_contrl = 4'd0;
      bus4.op_a       = 32'd0;
      bus4.op_b       = 32'd0;
      bus4.out_ready  = 1'b1;

      step(2);
      rst = 1'b0;
      #1;
      chk("reset out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("reset result", bus.result, 32'd0);
      chk("reset zero", {31'd0, bus.zero}, 32'd0);
      chk("reset illegal", {31'd0, bus.illegal}, 32'd0);
      chk("reset busy", {31'd0, bus.busy}, 32'd0);
      chk("reset in_ready", {31'd0, bus.in_ready}, 32'd1);

      // Back-to-back ADD then SUB.
      send(4'b0000, 32'd5, 32'd7);
      chk("add valid", {31'd0, bus.out_valid}, 32'd1);
      chk("add result", bus.result, 32'd12);
      chk("add zero", {31'd0, bus.zero}, 32'd0);
      send(4'b1000, 32'h1234, 32'h1234);
      chk("sub result", bus.result, 32'd0);
      chk("sub zero", {31'd0, bus.zero}, 32'd1);

      send(4'b0010, 32'hFFFFFFFF, 32'd1);
      chk("slt result", bus.result, 32'd1);
      send(4'b0011, 32'hFFFFFFFF, 32'd1);
      chk("sltu result", bus.result, 32'd0);
      chk("sltu zero", {31'd0, bus.zero}, 32'd1);
      step(1);

      send(4'b1101, 32'h80000000, 32'd4);
      chk("sra busy", {31'd0, bus.busy}, 32'd1);
      wait_valid(lat);
      chk("sra latency", lat, 32'd5);
      chk("sra result", bus.result, 32'hF8000000);
      step(1);

      // Same SRA on the SHIFT_STEP = 4 instance.
      bus4.in_valid   = 1'b1;
      bus4.alu_contrl = 4'b1101;
      bus4.op_a       = 32'h80000000;
      bus4.op_b       = 32'd4;
      step(1);
      bus4.in_valid = 1'b0;
      chk("sra4 busy", {31'd0, bus4.busy}, 32'd1);
      lat = 0;
      while (!bus4.out_valid && lat < 50) begin
         step(1);
         lat++;
      end
      chk("sra4 latency", lat + 1, 32'd2);
      chk("sra4 result", bus4.result, 32'hF8000000);
      step(1);

      // Backpressure on a long SLL, then release with a new ADD in the same cycle.
      bus.out_ready = 1'b0;
      send(4'b0001, 32'd1, 32'd31);
      wait_valid(lat);
      chk("sll latency", lat, 32'd32);
      for (int i = 0; i < 3; i++) begin
         step(1);
         chk("bp result", bus.result, 32'h80000000);
         chk("bp in_ready", {31'd0, bus.in_ready}, 32'd0);
      end
      bus.in_valid   = 1'b1;
      bus.alu_contrl = 4'b0000;
      bus.op_a       = 32'd2;
      bus.op_b       = 32'd3;
      bus.out_ready  = 1'b1;
      #1;
      chk("release in_ready", {31'd0, bus.in_ready}, 32'd1);
      step(1);
      bus.in_valid = 1'b0;
      chk("release add", bus.result, 32'd5);

      send(4'b1010, 32'd9, 32'd9);
      chk("illegal result", bus.result, 32'd0);
      chk("illegal flag", {31'd0, bus.illegal}, 32'd1);
      chk("illegal zero", {31'd0, bus.zero}, 32'd1);
      send(4'b0000, 32'd3, 32'd4);
      chk("legal clears", {31'd0, bus.illegal}, 32'd0);
      chk("legal result", bus.result, 32'd7);

      foreach (vecs[i]) begin
         send(vecs[i].c, vecs[i].a, vecs[i].b);
         wait_valid(lat);
         chk("vector result", bus.result, vecs[i].r);
      end
      step(1);

      // Reset in the middle of a shift aborts it.
      send(4'b0101, 32'hF0000000, 32'hABC00014);
      step(2);
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      #1;
      chk("abort out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("abort result", bus.result, 32'd0);
      chk("abort busy", {31'd0, bus.busy}, 32'd0);
      chk("abort in_ready", {31'd0, bus.in_ready}, 32'd1);
      send(4'b0000, 32'd1, 32'd1);
      chk("post-reset add", bus.result, 32'd2);
      step(25);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
